// File: rtl/tiny_riscv_uart_rx_periph_pkg.sv
// ---------------------------------------------------------------------------
// tiny_riscv_uart_rx_periph_pkg
//   Shared definitions for the UART receive peripheral of the tiny RISC-V SoC:
//   peripheral address bit indices, RX register select codes, STATUS bit
//   positions, the receiver FSM state type and the STATUS word packer.
//   No ports (package).
// ---------------------------------------------------------------------------
package tiny_riscv_uart_rx_periph_pkg;

  // Peripheral address bit indices decoded by the SoC top level
  localparam int PERIPH_BIT_LED       = 0;
  localparam int PERIPH_BIT_UART_DATA = 1;
  localparam int PERIPH_BIT_UART_CTRL = 2;
  localparam int PERIPH_BIT_7SEG1     = 3;
  localparam int PERIPH_BIT_7SEG2     = 4;
  localparam int PERIPH_BIT_UART_RX   = 5;

  // RX register select codes (i_reg_sel)
  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  // STATUS register bit positions
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [2:0] {
    RX_WAIT_IDLE,
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic logic [31:0] status_word(input logic [7:0] count,
                                              input logic       frame_err,
                                              input logic       overrun,
                                              input logic       full,
                                              input logic       not_empty);
    return {16'b0, count, 4'b0, frame_err, overrun, full, not_empty};
  endfunction

endpackage

// File: rtl/tiny_riscv_uart_rx_periph_if.sv
// ---------------------------------------------------------------------------
// tiny_riscv_uart_rx_periph_if
//   Peripheral bus between the SoC read/write decode and the UART RX block.
//   Signals (named from the peripheral's point of view):
//     i_sel          peripheral select
//     i_reg_sel      0 = DATA, 1 = STATUS
//     i_read_strobe  read request
//     i_write_strobe write request
//     i_write_data   write data (STATUS W1C bits)
//     o_read_data    registered read data
//   Modports: master (SoC side), slave (peripheral side).
// ---------------------------------------------------------------------------
interface tiny_riscv_uart_rx_periph_if;
  logic        i_sel;
  logic        i_reg_sel;
  logic        i_read_strobe;
  logic        i_write_strobe;
  logic [31:0] i_write_data;
  logic [31:0] o_read_data;

  modport master (
    output i_sel, i_reg_sel, i_read_strobe, i_write_strobe, i_write_data,
    input  o_read_data
  );

  modport slave (
    input  i_sel, i_reg_sel, i_read_strobe, i_write_strobe, i_write_data,
    output o_read_data
  );
endinterface

// File: rtl/tiny_riscv_uart_rx_periph_uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//   8N1 UART deserialiser: 2-FF input synchroniser plus receiver FSM.
//   Ports:
//     i_Clk        system clock
//     i_Rst        synchronous reset, active high
//     i_UART_RX    asynchronous serial input, idle high
//     o_byte       last assembled byte (valid while o_valid is high)
//     o_valid      1-cycle pulse on the stop-bit sample edge, stop bit high
//     o_frame_err  1-cycle pulse on the stop-bit sample edge, stop bit low
//   o_valid / o_frame_err are combinational so the consumer acts on the very
//   edge the stop bit is sampled.
// ---------------------------------------------------------------------------
module uart_rx_core
  import tiny_riscv_uart_rx_periph_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_UART_RX,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  // Synchroniser resets low so WAIT_IDLE only leaves once the real line has
  // been observed high; a reset taken mid-frame cannot fake an idle line.
  logic sync1_q, sync2_q, prev_q;
  logic rx_s;

  rx_state_t     state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;

  assign rx_s = sync2_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      state_q   <= RX_WAIT_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      sync1_q   <= i_UART_RX;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Shift register is pure data; a stale value is harmless after reset.
  always_ff @(posedge i_Clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    o_valid     = 1'b0;
    o_frame_err = 1'b0;

    case (state_q)
      RX_WAIT_IDLE: begin
        if (rx_s) state_d = RX_IDLE;
      end

      RX_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (prev_q && !rx_s) state_d = RX_START;
      end

      // Mid-start-bit check: a line that is high again was only a glitch.
      RX_START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      RX_DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      RX_STOP: begin
        if (clk_cnt_q == CNT_LAST) begin
          clk_cnt_d   = '0;
          state_d     = RX_IDLE;
          o_valid     = rx_s;
          o_frame_err = !rx_s;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      default: state_d = RX_WAIT_IDLE;
    endcase
  end

  assign o_byte = shift_q;

endmodule

// File: rtl/tiny_riscv_uart_rx_periph.sv
// ---------------------------------------------------------------------------
// tiny_riscv_uart_rx_periph
//   Memory-mapped UART receive peripheral: uart_rx_core feeds an RX FIFO that
//   is read through a DATA register (pop on read) and a STATUS register with
//   write-1-to-clear overrun / framing flags. Read data is registered.
//   Ports:
//     i_Clk      system clock
//     i_Rst      synchronous reset, active high
//     i_UART_RX  asynchronous serial input, idle high
//     bus        peripheral bus (tiny_riscv_uart_rx_periph_if.slave)
//     o_irq      interrupt request
//   Build option: UART_RX_IRQ_EN -- when defined, o_irq is a registered
//   !empty | overrun | framing_err; otherwise o_irq is tied low.
// ---------------------------------------------------------------------------
module tiny_riscv_uart_rx_periph
  import tiny_riscv_uart_rx_periph_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                            i_Clk,
  input  logic                            i_Rst,
  input  logic                            i_UART_RX,
  tiny_riscv_uart_rx_periph_if.slave      bus,
  output logic                            o_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_UART_RX   (i_UART_RX),
    .o_byte      (rx_byte),
    .o_valid     (rx_valid),
    .o_frame_err (rx_frame_err)
  );

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overrun_q, overrun_d;
  logic          framing_q, framing_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          empty, full;
  logic [PW-1:0] count;
  logic          data_rd, status_rd, status_wr;
  logic          pop, push, overrun_set;
  logic          wdata_unused;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign data_rd   = bus.i_sel && bus.i_read_strobe  && (bus.i_reg_sel == REG_DATA);
  assign status_rd = bus.i_sel && bus.i_read_strobe  && (bus.i_reg_sel == REG_STATUS);
  assign status_wr = bus.i_sel && bus.i_write_strobe && (bus.i_reg_sel == REG_STATUS);

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign pop         = data_rd && !empty;
  assign push        = rx_valid && (!full || pop);
  assign overrun_set = rx_valid && full && !pop;

  assign wdata_unused = ^{bus.i_write_data[31:4], bus.i_write_data[1:0]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    // Set takes priority over a simultaneous W1C clear.
    overrun_d = overrun_q;
    framing_d = framing_q;
    if (status_wr && bus.i_write_data[ST_OVERRUN])   overrun_d = 1'b0;
    if (status_wr && bus.i_write_data[ST_FRAME_ERR]) framing_d = 1'b0;
    if (overrun_set)  overrun_d = 1'b1;
    if (rx_frame_err) framing_d = 1'b1;

    rdata_d = rdata_q;
    if (data_rd) begin
      rdata_d = empty ? 32'h0 : {1'b1, 23'b0, mem_q[rd_ptr_q[AW-1:0]]};
    end else if (status_rd) begin
      rdata_d = status_word(8'(count), framing_q, overrun_q, full, !empty);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
      framing_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
      framing_q <= framing_d;
      rdata_q   <= rdata_d;
    end
  end

  // FIFO storage: data only, never reset.
  always_ff @(posedge i_Clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= rx_byte;
  end

  assign bus.o_read_data = rdata_q;

`ifdef UART_RX_IRQ_EN
  logic irq_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= !empty || overrun_q || framing_q;
    end
  end

  assign o_irq = irq_q;
`else
  assign o_irq = 1'b0;
`endif

endmodule

// File: tb/tb_tiny_riscv_uart_rx_periph.sv
module tb_tiny_riscv_uart_rx_periph;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

`ifdef UART_RX_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic irq;

  int vectors     = 0;
  int miscompares = 0;

  tiny_riscv_uart_rx_periph_if bus_if ();

  tiny_riscv_uart_rx_periph #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_UART_RX (rx),
    .bus       (bus_if.slave),
    .o_irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.i_sel          = 1'b0;
    bus_if.i_reg_sel      = 1'b0;
    bus_if.i_read_strobe  = 1'b0;
    bus_if.i_write_strobe = 1'b0;
    bus_if.i_write_data   = 32'h0;
  endtask

  task automatic read_reg(input logic r, output logic [31:0] v);
    bus_if.i_sel         = 1'b1;
    bus_if.i_reg_sel     = r;
    bus_if.i_read_strobe = 1'b1;
    tick();
    bus_idle();
    v = bus_if.o_read_data;
  endtask

  task automatic write_reg(input logic r, input logic [31:0] d);
    bus_if.i_sel          = 1'b1;
    bus_if.i_reg_sel      = r;
    bus_if.i_write_strobe = 1'b1;
    bus_if.i_write_data   = d;
    tick();
    bus_idle();
  endtask

  // Start bit driven just after edge S; returns just after edge S+40 with the
  // stop level still on the line. The stop bit is sampled on edge S+41.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop;
    repeat (CPB) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
    rx = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    rx  = 1'b1;
    bus_idle();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (bus_if.o_read_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h expected %h", bus_if.o_read_data, 32'h0);
    end
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b expected 0", irq);
    end
    read_reg(1'b1, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_status: got %h expected %h", v, 32'h0);
    end
    write_reg(1'b0, 32'hFFFF_FFFF);
    read_reg(1'b0, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL empty_data_read: got %h expected %h", v, 32'h0);
    end
  endtask

  task automatic test_single_byte();
    logic [31:0] v;
    send_byte(8'hA5);
    read_reg(1'b0, v);
    vectors++;
    if (v !== 32'h8000_00A5) begin
      miscompares++;
      $display("FAIL single_data: got %h expected %h", v, 32'h8000_00A5);
    end
    tick();
    vectors++;
    if (bus_if.o_read_data !== 32'h8000_00A5) begin
      miscompares++;
      $display("FAIL rdata_hold: got %h expected %h", bus_if.o_read_data, 32'h8000_00A5);
    end
    read_reg(1'b1, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL single_status: got %h expected %h", v, 32'h0);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] v;
    for (int b = 1; b <= 5; b++) send_byte(8'(b));
    read_reg(1'b1, v);
    // count=4, overrun, full, not-empty
    vectors++;
    if (v !== 32'h0000_0407) begin
      miscompares++;
      $display("FAIL overrun_status: got %h expected %h", v, 32'h0000_0407);
    end
    for (int i = 1; i <= 4; i++) begin
      read_reg(1'b0, v);
      vectors++;
      if (v !== (32'h8000_0000 | 32'(i))) begin
        miscompares++;
        $display("FAIL overrun_drain%0d: got %h expected %h", i, v, 32'h8000_0000 | 32'(i));
      end
    end
    read_reg(1'b1, v);
    vectors++;
    if (v !== 32'h0000_0004) begin
      miscompares++;
      $display("FAIL overrun_sticky: got %h expected %h", v, 32'h0000_0004);
    end
    write_reg(1'b1, 32'h4);
    read_reg(1'b1, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL overrun_clear: got %h expected %h", v, 32'h0);
    end
  endtask

  task automatic test_glitch_framing();
    logic [31:0] v;
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (8) tick();
    read_reg(1'b1, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL glitch_status: got %h expected %h", v, 32'h0);
    end
    send_frame(8'h55, 1'b0);
    rx = 1'b1;
    repeat (3) tick();
    read_reg(1'b1, v);
    vectors++;
    if (v !== 32'h0000_0008) begin
      miscompares++;
      $display("FAIL framing_status: got %h expected %h", v, 32'h0000_0008);
    end
    write_reg(1'b1, 32'h8);
    read_reg(1'b1, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL framing_clear: got %h expected %h", v, 32'h0);
    end
    // Clear written on the same edge a new framing error is detected.
    send_frame(8'h55, 1'b0);
    bus_if.i_sel          = 1'b1;
    bus_if.i_reg_sel      = 1'b1;
    bus_if.i_write_strobe = 1'b1;
    bus_if.i_write_data   = 32'h8;
    tick();
    bus_idle();
    rx = 1'b1;
    repeat (2) tick();
    read_reg(1'b1, v);
    vectors++;
    if (v !== 32'h0000_0008) begin
      miscompares++;
      $display("FAIL set_beats_clear: got %h expected %h", v, 32'h0000_0008);
    end
    write_reg(1'b1, 32'h8);
  endtask

  task automatic test_read_on_push();
    logic [31:0] v;
    for (int b = 8'h11; b <= 8'h14; b++) send_byte(8'(b));
    send_frame(8'h15, 1'b1);
    bus_if.i_sel         = 1'b1;
    bus_if.i_reg_sel     = 1'b0;
    bus_if.i_read_strobe = 1'b1;
    tick();
    bus_idle();
    rx = 1'b1;
    v  = bus_if.o_read_data;
    vectors++;
    if (v !== 32'h8000_0011) begin
      miscompares++;
      $display("FAIL push_pop_data: got %h expected %h", v, 32'h8000_0011);
    end
    repeat (2) tick();
    read_reg(1'b1, v);
    vectors++;
    if (v !== 32'h0000_0403) begin
      miscompares++;
      $display("FAIL push_pop_status: got %h expected %h", v, 32'h0000_0403);
    end
    for (int b = 8'h12; b <= 8'h15; b++) begin
      read_reg(1'b0, v);
      vectors++;
      if (v !== (32'h8000_0000 | 32'(b))) begin
        miscompares++;
        $display("FAIL push_pop_drain: got %h expected %h", v, 32'h8000_0000 | 32'(b));
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    send_byte(8'h77);
    rx = 1'b0;
    repeat (CPB) tick();
    repeat (3 * CPB) tick();
    repeat (CPB / 2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2 * CPB - 1) tick();
    rx = 1'b1;
    repeat (CPB) tick();
    send_byte(8'h3C);
    read_reg(1'b1, v);
    vectors++;
    if (v !== 32'h0000_0101) begin
      miscompares++;
      $display("FAIL midreset_status: got %h expected %h", v, 32'h0000_0101);
    end
    read_reg(1'b0, v);
    vectors++;
    if (v !== 32'h8000_003C) begin
      miscompares++;
      $display("FAIL midreset_data: got %h expected %h", v, 32'h8000_003C);
    end
    read_reg(1'b1, v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_empty: got %h expected %h", v, 32'h0);
    end
  endtask

  task automatic test_irq();
    logic [31:0] v;
    send_frame(8'h42, 1'b1);
    rx = 1'b1;
    tick();
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_push_edge: got %b expected 0", irq);
    end
    tick();
    vectors++;
    if (irq !== IRQ_ON) begin
      miscompares++;
      $display("FAIL irq_rise: got %b expected %b", irq, IRQ_ON);
    end
    read_reg(1'b0, v);
    vectors++;
    if (v !== 32'h8000_0042) begin
      miscompares++;
      $display("FAIL irq_data: got %h expected %h", v, 32'h8000_0042);
    end
    vectors++;
    if (irq !== IRQ_ON) begin
      miscompares++;
      $display("FAIL irq_pop_edge: got %b expected %b", irq, IRQ_ON);
    end
    tick();
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_fall: got %b expected 0", irq);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overrun();
    test_glitch_framing();
    test_read_on_push();
    test_reset_midframe();
    test_irq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
